// File: rtl/lb_pkg.sv
// Shared types for the load-balancing dispatcher: FSM states, request metadata layout, region stats.
// Pure declarations plus a combinational min-load region search; no state, no flow control.
package lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_PR_REQ   = 2'd3
    } lb_state_t;

    localparam int META_OID_W    = 16;
    localparam int META_METHOD_W = 32;
    localparam int META_MM_W     = 48;

    // MSB-first layout: {oid, has_body, has_hdr, method, meta_meta}
    typedef struct packed {
        logic [META_OID_W-1:0]    oid;
        logic                     has_body;
        logic                     has_hdr;
        logic [META_METHOD_W-1:0] method;
        logic [META_MM_W-1:0]     meta_meta;
    } req_meta_t;

    localparam int META_MM_LSB     = 0;
    localparam int META_METHOD_LSB = META_MM_LSB + META_MM_W;
    localparam int META_HDR_BIT    = META_METHOD_LSB + META_METHOD_W;
    localparam int META_BODY_BIT   = META_HDR_BIT + 1;
    localparam int META_OID_LSB    = META_BODY_BIT + 1;

    localparam int STAT_W      = 16;
    localparam int MAX_REGIONS = 16;
    localparam int IDX_W       = 4;

    typedef struct packed {
        logic [STAT_W-1:0] load;
        logic [STAT_W-1:0] loaded_oid;
    } region_stat_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } region_sel_t;

    // Strict less-than keeps the lowest index on equal loads.
    function automatic region_sel_t min_load_sel(
        input logic [MAX_REGIONS-1:0]        elig,
        input logic [MAX_REGIONS*STAT_W-1:0] loads
    );
        region_sel_t       sel;
        logic [STAT_W-1:0] best;
        sel.found = 1'b0;
        sel.idx   = '0;
        best      = '1;
        for (int r = 0; r < MAX_REGIONS; r++) begin
            if (elig[r] && (!sel.found || (loads[r*STAT_W +: STAT_W] < best))) begin
                sel.found = 1'b1;
                sel.idx   = IDX_W'(r);
                best      = loads[r*STAT_W +: STAT_W];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/queue_stream.sv
// Generic valid/ready FIFO, power-of-2 depth; head visible combinationally, 1 cycle push-to-head.
// s_ready = not full (and not in reset); a push against a full queue is refused even if popping.
module queue_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign o_s_ready = aresetn & ~w_full;
    assign o_m_valid = (r_count != '0);
    assign o_m_data  = r_mem[r_rd_ptr];
    assign w_push    = i_s_valid & o_s_ready;
    assign w_pop     = o_m_valid & i_m_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_s_data;
    end

endmodule

// File: rtl/lb_dispatch.sv
// Steers queued requests to the least-loaded region holding the operator, else requests reconfiguration.
// Latency 2 cycles queue head to disp_valid; disp_ready/pr_req_ready low holds the request, queue fills and drops tready.
module lb_dispatch
    import lb_pkg::*;
#(
    parameter int META_W    = 98,
    parameter int OID_W     = 16,
    parameter int N_REGIONS = 4,
    parameter int QDEPTH    = 16,
    parameter int MAX_LOAD  = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           meta_snk_tvalid,
    output logic                           meta_snk_tready,
    input  logic [META_W-1:0]              meta_snk_tdata,
    input  logic [N_REGIONS*2*OID_W-1:0]   region_stats_in,
    output logic                           disp_valid,
    input  logic                           disp_ready,
    output logic [$clog2(N_REGIONS)-1:0]   disp_region,
    output logic [META_W-1:0]              disp_meta,
    output logic                           pr_req_valid,
    input  logic                           pr_req_ready,
    output logic [$clog2(N_REGIONS)-1:0]   pr_region,
    output logic [OID_W-1:0]               pr_oid,
    input  logic [N_REGIONS-1:0]           pr_done,
    output logic [31:0]                    lb_ctrl,
    output logic [31:0]                    pr_ctrl
);
    localparam int RW = $clog2(N_REGIONS);
    localparam int SW = 2 * OID_W;

    logic                         w_fifo_vld;
    logic                         w_fifo_pop;
    logic [META_W-1:0]            w_fifo_dat;

    lb_state_t                    r_state;
    lb_state_t                    w_state_nxt;
    logic [META_W-1:0]            r_req;
    logic [N_REGIONS*SW-1:0]      r_stats;
    logic [N_REGIONS-1:0]         r_pr_busy;
    logic [OID_W-1:0]             r_pend_oid [N_REGIONS];
    logic [RW-1:0]                r_disp_region;
    logic [RW-1:0]                r_pr_region;
    logic [OID_W-1:0]             r_pr_oid;
    logic [31:0]                  r_lb_cnt;
    logic [15:0]                  r_pr_cnt;

    region_stat_t                 w_stat [N_REGIONS];
    logic [OID_W-1:0]             w_req_oid;
    logic [STAT_W-1:0]            w_req_oid_ext;
    logic [N_REGIONS-1:0]         w_match;
    logic [MAX_REGIONS-1:0]       w_cand_pad;
    logic [MAX_REGIONS-1:0]       w_free_pad;
    logic [MAX_REGIONS*STAT_W-1:0] w_load_pad;
    region_sel_t                  w_sel_c;
    region_sel_t                  w_sel_f;
    logic                         w_take_disp;
    logic                         w_take_pr;
    logic                         w_disp_hs;
    logic                         w_pr_hs;
    logic [N_REGIONS-1:0]         w_busy_set;

    queue_stream #(
        .WIDTH (META_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_s_valid (meta_snk_tvalid),
        .o_s_ready (meta_snk_tready),
        .i_s_data  (meta_snk_tdata),
        .o_m_valid (w_fifo_vld),
        .i_m_ready (w_fifo_pop),
        .o_m_data  (w_fifo_dat)
    );

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_stat
        assign w_stat[g] = '{load:       STAT_W'(r_stats[g*SW+OID_W +: OID_W]),
                             loaded_oid: STAT_W'(r_stats[g*SW +: OID_W])};
    end

    assign w_req_oid     = r_req[META_OID_LSB +: OID_W];
    assign w_req_oid_ext = STAT_W'(w_req_oid);

    // A busy region already being loaded with this oid counts as a match, so we wait rather than reconfigure twice.
    always_comb begin
        w_match    = '0;
        w_cand_pad = '0;
        w_free_pad = '0;
        w_load_pad = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            w_load_pad[r*STAT_W +: STAT_W] = w_stat[r].load;
            w_match[r]    = (w_stat[r].loaded_oid == w_req_oid_ext) ||
                            (r_pr_busy[r] && (r_pend_oid[r] == w_req_oid));
            w_cand_pad[r] = (w_stat[r].loaded_oid == w_req_oid_ext) && !r_pr_busy[r] &&
                            (w_stat[r].load < STAT_W'(MAX_LOAD));
            w_free_pad[r] = (w_stat[r].load == '0) && !r_pr_busy[r];
        end
    end

    assign w_sel_c = min_load_sel(w_cand_pad, w_load_pad);
    assign w_sel_f = min_load_sel(w_free_pad, w_load_pad);

    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        w_take_disp = 1'b0;
        w_take_pr   = 1'b0;
        w_disp_hs   = 1'b0;
        w_pr_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fifo_vld) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_req_oid == '0) begin
                    w_fifo_pop  = w_fifo_vld;
                    w_state_nxt = w_fifo_vld ? ST_EVAL : ST_IDLE;
                end else if (w_sel_c.found) begin
                    w_take_disp = 1'b1;
                    w_state_nxt = ST_DISPATCH;
                end else if (!(|w_match) && w_sel_f.found) begin
                    w_take_pr   = 1'b1;
                    w_state_nxt = ST_PR_REQ;
                end
            end
            ST_DISPATCH: begin
                if (disp_ready) begin
                    w_disp_hs   = 1'b1;
                    w_fifo_pop  = w_fifo_vld;
                    w_state_nxt = w_fifo_vld ? ST_EVAL : ST_IDLE;
                end
            end
            ST_PR_REQ: begin
                if (pr_req_ready) begin
                    w_pr_hs     = 1'b1;
                    w_state_nxt = ST_EVAL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy_set = w_pr_hs ? (N_REGIONS'(1) << r_pr_region) : '0;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_req         <= '0;
            r_stats       <= '0;
            r_pr_busy     <= '0;
            r_disp_region <= '0;
            r_pr_region   <= '0;
            r_pr_oid      <= '0;
            r_lb_cnt      <= '0;
            r_pr_cnt      <= '0;
            for (int r = 0; r < N_REGIONS; r++) r_pend_oid[r] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_stats   <= region_stats_in;
            // Set wins over a same-cycle pr_done for that region.
            r_pr_busy <= (r_pr_busy & ~pr_done) | w_busy_set;
            if (w_fifo_pop)  r_req         <= w_fifo_dat;
            if (w_take_disp) r_disp_region <= RW'(w_sel_c.idx);
            if (w_take_pr) begin
                r_pr_region <= RW'(w_sel_f.idx);
                r_pr_oid    <= w_req_oid;
            end
            if (w_disp_hs) r_lb_cnt <= r_lb_cnt + 32'd1;
            if (w_pr_hs) begin
                r_pr_cnt <= r_pr_cnt + 16'd1;
                r_pend_oid[r_pr_region] <= r_pr_oid;
            end
        end
    end

    assign disp_valid   = (r_state == ST_DISPATCH);
    assign disp_region  = r_disp_region;
    assign disp_meta    = r_req;
    assign pr_req_valid = (r_state == ST_PR_REQ);
    assign pr_region    = r_pr_region;
    assign pr_oid       = r_pr_oid;
    assign lb_ctrl      = r_lb_cnt;
    assign pr_ctrl      = {16'(r_pr_busy), r_pr_cnt};

endmodule

// File: tb/tb_lb_dispatch.sv
// Directed bench for lb_dispatch: dispatch choice, reconfiguration, load stall, backpressure, drop, reset abort.
module tb_lb_dispatch;
    localparam int N  = 4;
    localparam int MW = 98;
    localparam int ML = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            meta_snk_tvalid;
    logic            meta_snk_tready;
    logic [MW-1:0]   meta_snk_tdata;
    logic [N*32-1:0] region_stats_in;
    logic            disp_valid;
    logic            disp_ready;
    logic [1:0]      disp_region;
    logic [MW-1:0]   disp_meta;
    logic            pr_req_valid;
    logic            pr_req_ready;
    logic [1:0]      pr_region;
    logic [15:0]     pr_oid;
    logic [N-1:0]    pr_done;
    logic [31:0]     lb_ctrl;
    logic [31:0]     pr_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    lb_dispatch dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .meta_snk_tvalid (meta_snk_tvalid),
        .meta_snk_tready (meta_snk_tready),
        .meta_snk_tdata  (meta_snk_tdata),
        .region_stats_in (region_stats_in),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_region     (disp_region),
        .disp_meta       (disp_meta),
        .pr_req_valid    (pr_req_valid),
        .pr_req_ready    (pr_req_ready),
        .pr_region       (pr_region),
        .pr_oid          (pr_oid),
        .pr_done         (pr_done),
        .lb_ctrl         (lb_ctrl),
        .pr_ctrl         (pr_ctrl)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic set_stat(input int r, input int load, input int oid);
        region_stats_in[r*32 +: 32] = {16'(load), 16'(oid)};
    endtask

    function automatic logic [MW-1:0] mk(input int oid, input int tag);
        return {16'(oid), 1'b1, 1'b0, 32'hCAFE0000 | 32'(tag), 48'(tag)};
    endfunction

    task automatic push1(input logic [MW-1:0] m);
        check("push_tready", meta_snk_tready, 1'b1);
        meta_snk_tvalid = 1'b1;
        meta_snk_tdata  = m;
        tick();
        meta_snk_tvalid = 1'b0;
    endtask

    initial begin
        int          sent;
        int          got;
        int          mism;
        logic        bad;
        logic        acc;
        logic [MW-1:0] m;

        aresetn         = 1'b0;
        meta_snk_tvalid = 1'b0;
        meta_snk_tdata  = '0;
        region_stats_in = '0;
        disp_ready      = 1'b1;
        pr_req_ready    = 1'b0;
        pr_done         = '0;
        repeat (3) tick();
        check("rst_tready", meta_snk_tready, 1'b0);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_pr_valid", pr_req_valid, 1'b0);
        check("rst_lb_ctrl", lb_ctrl, 32'd0);
        check("rst_pr_ctrl", pr_ctrl, 32'd0);
        check("rst_disp_meta", disp_meta, '0);
        aresetn = 1'b1;
        tick();
        check("rel_tready", meta_snk_tready, 1'b1);

        // Two matching regions: least loaded wins, 2 cycles after enqueue
        set_stat(0, 3, 5);
        set_stat(1, 1, 5);
        tick(); tick();
        m = mk(5, 1);
        push1(m);
        check("A_lat1", disp_valid, 1'b0);
        tick();
        check("A_lat2", disp_valid, 1'b0);
        tick();
        check("A_valid", disp_valid, 1'b1);
        check("A_region", disp_region, 2'd1);
        check("A_meta", disp_meta, m);
        tick();
        check("A_lb_ctrl", lb_ctrl, 32'd1);
        check("A_valid_drop", disp_valid, 1'b0);

        // No region holds the operator: reconfigure region 0
        region_stats_in = '0;
        tick(); tick();
        m = mk(7, 2);
        push1(m);
        for (int i = 0; i < 20 && !pr_req_valid; i++) tick();
        check("B_pr_valid", pr_req_valid, 1'b1);
        check("B_pr_region", pr_region, 2'd0);
        check("B_pr_oid", pr_oid, 16'd7);
        tick(); tick();
        check("B_pr_hold", {pr_req_valid, pr_oid}, {1'b1, 16'd7});
        pr_req_ready = 1'b1;
        tick();
        pr_req_ready = 1'b0;
        check("B_pr_ctrl", pr_ctrl, 32'h0001_0001);
        check("B_pr_valid_drop", pr_req_valid, 1'b0);
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (pr_req_valid || disp_valid) bad = 1'b1;
        end
        check("B_wait_busy", bad, 1'b0);
        set_stat(0, 0, 7);
        tick(); tick();
        pr_done = 4'b0001;
        tick();
        pr_done = '0;
        for (int i = 0; i < 10 && !disp_valid; i++) tick();
        check("B_disp_valid", disp_valid, 1'b1);
        check("B_disp_region", disp_region, 2'd0);
        check("B_disp_meta", disp_meta, m);
        check("B_busy_clear", pr_ctrl[31:16], 16'd0);
        tick();
        check("B_lb_ctrl", lb_ctrl, 32'd2);

        // Only matching region is full: wait, then dispatch once load drops
        region_stats_in = '0;
        set_stat(2, ML, 9);
        tick(); tick();
        push1(mk(9, 3));
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (pr_req_valid || disp_valid) bad = 1'b1;
        end
        check("C_stall", bad, 1'b0);
        set_stat(2, ML - 1, 9);
        for (int i = 0; i < 10 && !disp_valid; i++) tick();
        check("C_disp_valid", disp_valid, 1'b1);
        check("C_disp_region", disp_region, 2'd2);
        tick();
        check("C_lb_ctrl", lb_ctrl, 32'd3);

        // disp_ready low: outputs held steady
        region_stats_in = '0;
        set_stat(1, 2, 4);
        tick(); tick();
        disp_ready = 1'b0;
        m = mk(4, 4);
        push1(m);
        for (int i = 0; i < 10 && !disp_valid; i++) tick();
        check("D_disp_valid", disp_valid, 1'b1);
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (disp_valid !== 1'b1 || disp_region !== 2'd1 || disp_meta !== m) bad = 1'b1;
        end
        check("D_hold", bad, 1'b0);
        disp_ready = 1'b1;
        tick();
        check("D_valid_drop", disp_valid, 1'b0);
        check("D_lb_ctrl", lb_ctrl, 32'd4);

        // 20 back-to-back pushes against a stalled output
        disp_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            meta_snk_tvalid = (sent < 20);
            meta_snk_tdata  = mk(4, 100 + sent);
            acc = meta_snk_tready && meta_snk_tvalid;
            tick();
            if (acc) sent++;
        end
        check("E_accepted", sent, 17);
        check("E_tready_full", meta_snk_tready, 1'b0);
        disp_ready = 1'b1;
        got  = 0;
        mism = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            meta_snk_tvalid = (sent < 20);
            meta_snk_tdata  = mk(4, 100 + sent);
            acc = meta_snk_tready && meta_snk_tvalid;
            if (disp_valid) begin
                if (disp_meta !== mk(4, 100 + got)) mism++;
                got++;
            end
            tick();
            if (acc) sent++;
        end
        meta_snk_tvalid = 1'b0;
        check("E_sent", sent, 20);
        check("E_received", got, 20);
        check("E_order", mism, 0);
        check("E_lb_ctrl", lb_ctrl, 32'd24);

        // oid 0 is dropped without counting
        push1(mk(0, 5));
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (pr_req_valid || disp_valid) bad = 1'b1;
        end
        check("F_no_out", bad, 1'b0);
        check("F_lb_ctrl", lb_ctrl, 32'd24);
        check("F_pr_cnt", pr_ctrl[15:0], 16'd1);

        // Reset while a reconfiguration request is pending
        region_stats_in = '0;
        set_stat(0, 1, 3);
        tick(); tick();
        pr_req_ready = 1'b0;
        push1(mk(11, 6));
        for (int i = 0; i < 10 && !pr_req_valid; i++) tick();
        check("G_pr_valid", pr_req_valid, 1'b1);
        check("G_pr_region", pr_region, 2'd1);
        check("G_pr_oid", pr_oid, 16'd11);
        aresetn = 1'b0;
        tick();
        check("G_pr_valid_rst", pr_req_valid, 1'b0);
        check("G_pr_region_rst", pr_region, 2'd0);
        check("G_pr_oid_rst", pr_oid, 16'd0);
        check("G_disp_valid_rst", disp_valid, 1'b0);
        check("G_tready_rst", meta_snk_tready, 1'b0);
        check("G_lb_ctrl_rst", lb_ctrl, 32'd0);
        check("G_pr_ctrl_rst", pr_ctrl, 32'd0);
        check("G_disp_meta_rst", disp_meta, '0);
        aresetn = 1'b1;
        pr_req_ready = 1'b1;
        tick();
        check("G_tready_rel", meta_snk_tready, 1'b1);
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (pr_req_valid || disp_valid) bad = 1'b1;
        end
        check("G_aborted", bad, 1'b0);
        check("G_pr_ctrl_after", pr_ctrl, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
